cdc_toggle_rx_ctrl: RTL and testbench
=====================================

// Module: cdc_toggle_rx_ctrl
// PURPOSE
//  Receive-side controller for a 2-phase (toggle) req/ack handshake carrying a DATA_WIDTH word
//  from an asynchronous source domain into clk. Synchronises req via an internal doublesync
//  (WIDTH=1), edge-detects it, captures the held source word and presents it on a valid/ready
//  stream. Returns an ack toggle only after the consumer takes the word. Sits in front of any
//  register bank or FIFO fed from a foreign clock.
// PARAMETERS
//  DATA_WIDTH  32  width of async_data / out_data
//  CNT_WIDTH   16  width of xfer_count (wraps)
// PORTS
//  clk          in   1           clock; all logic on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  async_req    in   1           source req toggle (async to clk); each transition = one new word
//  async_data   in   DATA_WIDTH  source word; sender holds stable from req toggle until ack toggle
//  async_ack    out  1           ack toggle back to source, driven direct from a flop
//  out_valid    out  1           out_data holds an untaken word
//  out_ready    in   1           consumer accepts word when out_valid & out_ready at posedge
//  out_data     out  DATA_WIDTH  captured word
//  xfer_count   out  CNT_WIDTH   completed transfers, wraps 2^CNT_WIDTH-1 -> 0
//  proto_err    out  1           sticky: req edge seen while not IDLE
//  err_clr      in   1           synchronous clear of proto_err
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; sync flops, req_prev, async_ack, out_valid, proto_err,
//   xfer_count=0; out_data=0. doublesync reset port driven by ~reset_n. Source must also
//   reset its req toggle to 0; mid-transfer reset drops any held word without ack.
//  Sync: req_s = doublesync(async_req) (2 flops); req_prev <= req_s each cycle;
//   req_edge = req_s ^ req_prev (single-cycle pulse per toggle).
//  FSM (2 states):
//   IDLE: out_valid=0. On req_edge: out_data <= async_data, out_valid <= 1, -> HOLD.
//   HOLD: out_valid=1, out_data stable. On out_valid & out_ready: out_valid <= 0,
//    async_ack <= ~async_ack, xfer_count <= xfer_count+1, -> IDLE (same edge).
//  Latency: async_req toggles, first sampled at edge E1 -> req_s at E2 -> out_valid=1 after E3.
//   Ready already high: transfer at E4, ack toggles after E4. Min 1 cycle of out_valid.
//  out_ready while out_valid=0 is ignored; no combinational path ready->ack or req->valid.
//  req_edge in HOLD (protocol violation): proto_err <= 1, edge dropped, out_data unchanged,
//   no extra ack. err_clr=1 clears proto_err; err_clr and new violation same cycle -> stays 1.
//  req_edge in IDLE on same cycle as HOLD->IDLE cannot occur (FSM is in HOLD); next edge is
//   taken the cycle it is detected once back in IDLE.
//  async_data is sampled only on the capture edge; sender stability guaranteed by protocol
//   (>=3 cycles since toggle), so no data synchronisers.
// TESTING
//  1 Reset: reset_n=0 mid-HOLD -> out_valid=0, async_ack=0, xfer_count=0, proto_err=0 immediately.
//  2 Single xfer: data=0xDEADBEEF, toggle req 0->1, ready=1 -> out_valid rises 3 cycles later with
//    0xDEADBEEF, accepted next edge, async_ack 0->1, xfer_count=1.
//  3 Backpressure: ready=0 for 10 cycles -> out_valid/out_data held, async_ack unchanged; ready=1 ->
//    one transfer, one ack toggle.
//  4 Back-to-back: sender toggles req on each ack, 8 words 0..7 -> out_data sequence 0..7 in order,
//    xfer_count=8, async_ack toggled 8 times, proto_err=0.
//  5 Violation: toggle req twice while in HOLD -> proto_err=1, out_data = first word, single ack;
//    err_clr pulse -> proto_err=0.
//  6 Wrap: CNT_WIDTH=4, 17 transfers -> xfer_count=1.

Source files
------------

// File: rtl/cdc_toggle_rx_ctrl.sv
// Receive side of a 2-phase req/ack crossing: syncs the req toggle,
// captures the held source word and hands it out on valid/ready.

module doublesync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

module cdc_toggle_rx_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  async_req,
   input  logic [DATA_WIDTH-1:0] async_data,
   output logic                  async_ack,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  xfer_count,
   output logic                  proto_err,
   input  logic                  err_clr
);

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic                  req_s;
   logic                  req_prev_q;
   logic                  req_edge;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  sync_rst;

   assign sync_rst = ~reset_n;

   doublesync #(
      .WIDTH(1)
   ) u_req_sync (
      .clk (clk),
      .rst (sync_rst),
      .d   (async_req),
      .q   (req_s)
   );

   assign req_edge = req_s ^ req_prev_q;

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_edge) begin
               data_d  = async_data;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               ack_d   = ~ack_q;
               cnt_d   = cnt_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // a new violation wins over a clear in the same cycle
      err_d = (err_q & ~err_clr) | (req_edge & (state_q == S_HOLD));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         req_prev_q <= 1'b0;
         ack_q      <= 1'b0;
         data_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_prev_q <= req_s;
         ack_q      <= ack_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign async_ack  = ack_q;
   assign out_valid  = (state_q == S_HOLD);
   assign out_data   = data_q;
   assign xfer_count = cnt_q;
   assign proto_err  = err_q;

endmodule

// File: tb/tb_cdc_toggle_rx_ctrl.sv
// Randomised bench for cdc_toggle_rx_ctrl against a queue-based
// model of the toggle handshake and the stream it produces.

module tb_cdc_toggle_rx_ctrl;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk;
   logic          reset_n;
   logic          async_req;
   logic [DW-1:0] async_data;
   logic          async_ack;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] xfer_count;
   logic          proto_err;
   logic          err_clr;

   int            n_vec;
   int            n_err;
   int            acc_cnt;
   int            rdy_mode;
   bit            mon_en;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] held;
   logic          ack0;

   cdc_toggle_rx_ctrl #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .async_req (async_req),
      .async_data(async_data),
      .async_ack (async_ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .xfer_count(xfer_count),
      .proto_err (proto_err),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // consumer: forced low, forced high or coin-flip each cycle
   always @(posedge clk) begin
      #2;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 1);
   end

   // model: every accepted word pops the sent queue, toggles ack
   always @(negedge clk) begin
      if (reset_n && mon_en) begin
         chk("ack_parity", async_ack, 64'(acc_cnt % 2));
         chk("xfer_count", xfer_count, 64'(acc_cnt % (1 << CW)));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
            else chk("out_data", out_data, exp_q.pop_front());
            acc_cnt++;
         end
      end
   end

   task automatic do_reset();
      mon_en    = 1'b0;
      reset_n   = 1'b0;
      async_req = 1'b0;
      err_clr   = 1'b0;
      exp_q.delete();
      acc_cnt   = 0;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      mon_en  = 1'b1;
   endtask

   task automatic wait_ack();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk);
         #1;
         done = (async_ack == async_req);
      end
      #1;
      if (!done) chk("ack_timeout", 0, 1);
   endtask

   task automatic wait_valid();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk);
         #1;
         done = out_valid;
      end
      #1;
      if (!done) chk("valid_timeout", 0, 1);
   endtask

   task automatic toggle(input logic [DW-1:0] w, input bit push);
      async_data = w;
      if (push) exp_q.push_back(w);
      async_req = ~async_req;
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      toggle(w, 1'b1);
      wait_ack();
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      acc_cnt    = 0;
      rdy_mode   = 0;
      mon_en     = 1'b0;
      out_ready  = 1'b0;
      async_data = '0;
      async_req  = 1'b0;
      err_clr    = 1'b0;
      reset_n    = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      do_reset();

      // single transfer and its latency
      rdy_mode = 1;
      @(posedge clk);
      #2;
      toggle(32'hDEADBEEF, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid_e2", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid_e3", out_valid, 1);
      chk("lat_data", out_data, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      chk("single_ack", async_ack, 1);
      chk("single_cnt", xfer_count, 1);
      #1;

      // reset while holding a word with an error flagged
      rdy_mode = 0;
      toggle(32'h1234_5678, 1'b0);
      wait_valid();
      toggle(32'h0BAD_0BAD, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      chk("pre_rst_err", proto_err, 1);
      mon_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ack", async_ack, 0);
      chk("mid_rst_cnt", xfer_count, 0);
      chk("mid_rst_err", proto_err, 0);
      chk("mid_rst_data", out_data, 0);
      do_reset();

      // backpressure: word and ack held while ready is low
      rdy_mode = 0;
      toggle(32'hCAFE_F00D, 1'b1);
      wait_valid();
      ack0 = async_ack;
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 32'hCAFE_F00D);
         chk("bp_ack", async_ack, ack0);
      end
      @(posedge clk);
      #2;
      rdy_mode = 1;
      wait_ack();
      repeat (4) @(posedge clk);
      #2;
      chk("bp_one_xfer", xfer_count, 1);

      // back-to-back words 0..7
      do_reset();
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) send_word(DW'(i));
      repeat (4) @(posedge clk);
      #2;
      chk("b2b_cnt", xfer_count, 8);
      chk("b2b_ack", async_ack, 0);
      chk("b2b_err", proto_err, 0);
      chk("b2b_drained", exp_q.size(), 0);

      // two extra toggles while holding: flagged, dropped
      rdy_mode = 0;
      held = $urandom;
      toggle(held, 1'b1);
      wait_valid();
      chk("viol_err_pre", proto_err, 0);
      toggle(~held, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      toggle(held ^ 32'h5A5A_5A5A, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      chk("viol_err", proto_err, 1);
      chk("viol_data", out_data, held);
      chk("viol_valid", out_valid, 1);
      rdy_mode = 1;
      wait_ack();
      repeat (8) @(posedge clk);
      #2;
      chk("viol_one_ack", xfer_count, 9);
      chk("viol_err_sticky", proto_err, 1);
      err_clr = 1'b1;
      @(posedge clk);
      #2;
      err_clr = 1'b0;
      chk("viol_clr", proto_err, 0);

      // counter wrap at 4 bits
      do_reset();
      rdy_mode = 2;
      for (int i = 0; i < 17; i++) send_word($urandom);
      repeat (4) @(posedge clk);
      #2;
      chk("wrap_cnt", xfer_count, 1);

      // random traffic with idle gaps and random ready
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #2;
         send_word($urandom);
      end
      repeat (4) @(posedge clk);
      #2;
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_err", proto_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
